// File: rtl/pulses_to_units_if.sv
// Start/result bundle for the pulse-count to BCD unit converter.
// The requester drives update and the operands; the converter drives the result and ready.
interface pulses_to_units_if #(
  parameter int BCD_DIGITS = 6,
  parameter int BIN_W      = 40
);
  logic                      update;
  logic [BIN_W-1:0]          pulse_count;
  logic [BCD_DIGITS*4-1:0]   pulses_per_unit;
  logic [BCD_DIGITS*4-1:0]   units_bcd;
  logic                      overflow;
  logic                      ready;

  modport master (
    output update, pulse_count, pulses_per_unit,
    input  units_bcd, overflow, ready
  );

  modport slave (
    input  update, pulse_count, pulses_per_unit,
    output units_bcd, overflow, ready
  );
endinterface

// File: rtl/pulses_to_units.sv
// Converts a binary pulse count to round(count / ppu) in BCD, with ppu given in BCD.
// Fixed 67 ce-enabled edges per conversion; update is ignored while ready is low.
module pulses_to_units #(
  parameter int BCD_DIGITS = 6,
  parameter int BIN_W      = 40,
  parameter int HALF_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  pulses_to_units_if.slave bus
);
  localparam int BCD_W = BCD_DIGITS * 4;
  localparam int CNT_W = 6;
  localparam logic [BIN_W-1:0] MAX_Q = BIN_W'(10**BCD_DIGITS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_PPU, ST_DIV, ST_ROUND, ST_BCD} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    w_last;

  logic [BCD_W-1:0]        r_ppu_bcd;
  logic [HALF_W-1:0]       r_ppu_bin;
  logic [HALF_W:0]         r_rem;
  logic [BIN_W-1:0]        r_quo;
  logic [HALF_W-1:0]       r_bin;
  logic [BCD_W-1:0]        r_bcd;
  logic                    r_flag;
  logic [BCD_W-1:0]        r_units;
  logic                    r_ovf;
  logic                    r_ready;

  logic [3:0]              w_digit;
  logic [HALF_W-1:0]       w_ppu_step;
  logic [HALF_W:0]         w_ppu_ext;
  logic [HALF_W:0]         w_rem_sh;
  logic                    w_q_bit;
  logic [HALF_W:0]         w_rem_next;
  logic                    w_round_up;
  logic [BIN_W-1:0]        w_q_rnd;
  logic                    w_sat;
  logic [BCD_W-1:0]        w_bcd_adj;
  logic [BCD_W+HALF_W-1:0] w_dd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (ce) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.update) w_state_next = ST_PPU;
      ST_PPU: begin
        w_last = (r_cnt == CNT_W'(BCD_DIGITS - 1));
        if (w_last) w_state_next = ST_DIV;
      end
      ST_DIV: begin
        w_last = (r_cnt == CNT_W'(BIN_W - 1));
        if (w_last) w_state_next = ST_ROUND;
      end
      ST_ROUND: begin
        w_last       = 1'b1;
        w_state_next = ST_BCD;
      end
      ST_BCD: begin
        w_last = (r_cnt == CNT_W'(HALF_W - 1));
        if (w_last) w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Datapath steps; digits above 9 are accumulated with their raw value.
  always_comb begin
    w_digit    = r_ppu_bcd[BCD_W-1 -: 4];
    w_ppu_step = HALF_W'(r_ppu_bin * HALF_W'(10)) + HALF_W'(w_digit);
    w_ppu_ext  = {1'b0, r_ppu_bin};
    w_rem_sh   = {r_rem[HALF_W-1:0], r_quo[BIN_W-1]};
    w_q_bit    = (w_rem_sh >= w_ppu_ext);
    w_rem_next = w_q_bit ? (w_rem_sh - w_ppu_ext) : w_rem_sh;
    w_round_up = (r_rem >= (w_ppu_ext - r_rem));
    w_q_rnd    = r_quo + BIN_W'(w_round_up);
    // Saturation is judged after rounding so x.5 just below the limit still overflows.
    w_sat      = (r_ppu_bin == '0) || (w_q_rnd > MAX_Q);
    w_bcd_adj  = r_bcd;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
    w_dd = {w_bcd_adj, r_bin} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_ppu_bcd <= '0;
      r_ppu_bin <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_flag    <= 1'b0;
      r_units   <= '0;
      r_ovf     <= 1'b0;
      r_ready   <= 1'b1;
    end else if (ce) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.update) begin
            r_quo     <= bus.pulse_count;
            r_ppu_bcd <= bus.pulses_per_unit;
            r_ppu_bin <= '0;
            r_rem     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_flag    <= 1'b0;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
          end
        end
        ST_PPU: begin
          r_ppu_bin <= w_ppu_step;
          r_ppu_bcd <= {r_ppu_bcd[BCD_W-5:0], 4'b0000};
          r_cnt     <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
        ST_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[BIN_W-2:0], w_q_bit};
          r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
        ST_ROUND: begin
          r_bin  <= w_sat ? MAX_Q[HALF_W-1:0] : w_q_rnd[HALF_W-1:0];
          r_flag <= w_sat;
          r_cnt  <= '0;
        end
        ST_BCD: begin
          r_bcd <= w_dd[BCD_W+HALF_W-1:HALF_W];
          r_bin <= w_dd[HALF_W-1:0];
          r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
          if (w_last) begin
            r_units <= w_dd[BCD_W+HALF_W-1:HALF_W];
            r_ovf   <= r_flag;
            r_ready <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.units_bcd = r_units;
  assign bus.overflow  = r_ovf;
  assign bus.ready     = r_ready;
endmodule

// File: tb/tb_pulses_to_units.sv
// Directed bench for pulses_to_units: hand-computed results, latency, ce stretching and reset.
module tb_pulses_to_units;
  logic clk = 1'b0;
  logic rst;
  logic ce;
  int   n_chk = 0;
  int   n_bad = 0;
  int   lat;

  pulses_to_units_if bus ();

  pulses_to_units dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts a conversion with ce=1 and returns the number of cycles ready stayed low.
  task automatic conv(input logic [39:0] pc, input logic [23:0] ppu, output int cycles);
    @(negedge clk);
    bus.pulse_count     = pc;
    bus.pulses_per_unit = ppu;
    bus.update          = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
    cycles     = 0;
    while (!bus.ready && cycles < 300) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst                 = 1'b1;
    ce                  = 1'b1;
    bus.update          = 1'b0;
    bus.pulse_count     = '0;
    bus.pulses_per_unit = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_units", 64'(bus.units_bcd), 64'h0);
    chk("rst_ovf",   64'(bus.overflow), 64'd0);
    rst = 1'b0;

    conv(40'd300, 24'h000100, lat);
    chk("basic_units", 64'(bus.units_bcd), 64'h000003);
    chk("basic_ovf",   64'(bus.overflow), 64'd0);
    chk("basic_lat",   64'(lat), 64'd67);

    conv(40'd149, 24'h000100, lat);
    chk("rnd149", 64'(bus.units_bcd), 64'h000001);
    conv(40'd150, 24'h000100, lat);
    chk("rnd150", 64'(bus.units_bcd), 64'h000002);
    conv(40'd49, 24'h000100, lat);
    chk("rnd49", 64'(bus.units_bcd), 64'h000000);

    conv(40'd999998000001, 24'h999999, lat);
    chk("max_units", 64'(bus.units_bcd), 64'h999999);
    chk("max_ovf",   64'(bus.overflow), 64'd0);

    conv(40'd1000000, 24'h000001, lat);
    chk("sat_units", 64'(bus.units_bcd), 64'h999999);
    chk("sat_ovf",   64'(bus.overflow), 64'd1);

    conv(40'd1999999, 24'h000002, lat);
    chk("half_sat_units", 64'(bus.units_bcd), 64'h999999);
    chk("half_sat_ovf",   64'(bus.overflow), 64'd1);

    conv(40'd5, 24'h000000, lat);
    chk("div0_units", 64'(bus.units_bcd), 64'h999999);
    chk("div0_ovf",   64'(bus.overflow), 64'd1);
    chk("div0_lat",   64'(lat), 64'd67);

    // ce alternates each clock; a second update mid-run must be ignored.
    @(negedge clk);
    bus.pulse_count     = 40'd123456;
    bus.pulses_per_unit = 24'h000001;
    bus.update          = 1'b1;
    ce                  = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
    ce         = 1'b0;
    lat        = 0;
    while (!bus.ready && lat < 400) begin
      lat++;
      if (lat == 20) begin
        chk("hold_units", 64'(bus.units_bcd), 64'h999999);
        chk("hold_ovf",   64'(bus.overflow), 64'd1);
      end
      if (lat == 40) begin
        bus.pulse_count     = 40'd777;
        bus.pulses_per_unit = 24'h000003;
        bus.update          = 1'b1;
      end
      if (lat == 44) bus.update = 1'b0;
      @(negedge clk);
      ce = ~ce;
    end
    ce         = 1'b1;
    bus.update = 1'b0;
    chk("ce_units", 64'(bus.units_bcd), 64'h123456);
    chk("ce_ovf",   64'(bus.overflow), 64'd0);
    chk("ce_lat",   64'(lat), 64'd134);
    repeat (3) @(negedge clk);
    chk("ce_no_requeue", 64'(bus.ready), 64'd1);

    // Reset mid-conversion discards the partial result and clears the outputs.
    conv(40'd300, 24'h000100, lat);
    chk("pre_rst_units", 64'(bus.units_bcd), 64'h000003);
    @(negedge clk);
    bus.pulse_count     = 40'd900;
    bus.pulses_per_unit = 24'h000100;
    bus.update          = 1'b1;
    @(negedge clk);
    bus.update = 1'b0;
    repeat (19) @(negedge clk);
    chk("busy_before_rst", 64'(bus.ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 64'(bus.ready), 64'd1);
    chk("mid_rst_units", 64'(bus.units_bcd), 64'h0);
    chk("mid_rst_ovf",   64'(bus.overflow), 64'd0);
    conv(40'd300, 24'h000100, lat);
    chk("post_rst_units", 64'(bus.units_bcd), 64'h000003);
    chk("post_rst_lat",   64'(lat), 64'd67);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/pulses_to_units.md
# pulses_to_units

Sequential converter from a binary pulse count to a BCD unit count: `units = round(pulse_count / pulses_per_unit)`, with `pulses_per_unit` given in BCD. It is the inverse of the timing path that turns BCD unit settings into binary pulse counts. It feeds measured durations (key-down, key-up, gap lengths) back into the BCD domain for display and for auto-calibration of the configuration options. Each conversion is multi-cycle and is started by a strobe; `ready` flags completion.

## Interface
- `BCD_DIGITS`, 6: digits of `pulses_per_unit` and `units_bcd` (`UNIT_BCD_W`).
- `BIN_W`, 40: width of `pulse_count` (`PULSE_CNT_W`).
- `HALF_W`, 20: width of the binary divisor and quotient (`PULSE_CNT_HALF_W`); 999999 < 2^20.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high. Overrides `ce`.
- `ce` in 1: clock enable. When 0, all state and outputs freeze.
- `update` in 1: start strobe. Sampled only in IDLE with `ce`=1.
- `pulse_count` in BIN_W: binary dividend. Captured on start.
- `pulses_per_unit` in BCD_DIGITS*4: BCD divisor. Captured on start.
- `units_bcd` out BCD_DIGITS*4: last result. Reset value 0.
- `overflow` out 1: last result was saturated. Reset value 0.
- `ready` out 1: 1 in IDLE, 0 while busy. Reset value 1.

## Operation
- States: IDLE → PPU → DIV → ROUND → BCD → IDLE. Each transition and step advances only on an edge with `ce`=1.
- IDLE with `update`=1:
  - capture both inputs into internal registers;
  - clear working registers;
  - `ready`←0;
  - go to PPU.
- PPU, 6 steps, most-significant digit first: `ppu_bin ← ppu_bin*10 + digit` (HALF_W bits). Digits >9 are used with their raw value; the result is truncated to HALF_W.
- DIV, 40 steps, restoring division, one quotient bit per step, MSB first.
  - Remainder register is HALF_W+1 bits.
  - Quotient register is BIN_W bits.
  - If `ppu_bin`=0, DIV still runs for the full 40 steps, but its result is discarded.
- ROUND, 1 step:
  - If `rem >= ppu_bin - rem`, increment the quotient (half rounds up).
  - Then saturate: if `ppu_bin`=0, or the quotient exceeds 999999, force the quotient to 999999 and set an internal overflow flag.
  - The saturation check is applied after the increment, so 999999.5 saturates with overflow=1.
- BCD, 20 steps, double-dabble on the low HALF_W quotient bits. Before each shift, add 3 to every BCD nibble that is ≥5.
- Leaving BCD, on the same edge:
  - `units_bcd`←result;
  - `overflow`←flag;
  - `ready`←1;
  - go to IDLE.
- `units_bcd` and `overflow` change only on that completion edge. They hold the previous result for the whole conversion.
- `update` while busy is ignored; it is not queued.
- `update` held high continuously restarts a conversion on each return to IDLE. The re-capture occurs on the edge after `ready` rises.
- `rst`=1 at any time, including mid-conversion:
  - next edge goes to IDLE with `ready`=1, `units_bcd`=0, `overflow`=0;
  - any partial result is discarded.

## Timing
- Capture edge = edge 0. `ready` is 0 from edge 0.
- Completion: the 67th `ce`-enabled edge after edge 0 (6+40+1+20). Outputs and `ready`=1 are visible after that edge.
- Fixed latency, independent of the data values, including divide-by-zero.
- `ce`=0 cycles stretch the wall-clock latency but do not change the result.
- Earliest next start: the first `ce` edge after `ready` rises.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- `pulse_count`=300, `pulses_per_unit`=0x000100 → `units_bcd`=0x000003, `overflow`=0. `ready` is low for exactly 67 cycles, then high.
- Rounding, `ppu`=0x000100:
  - `pulse_count`=149 → 0x000001;
  - `pulse_count`=150 → 0x000002;
  - `pulse_count`=49 → 0x000000.
- Maximum exact: `pulse_count`=999998000001, `ppu`=0x999999 → 0x999999, `overflow`=0.
- Saturation:
  - `pulse_count`=1000000, `ppu`=0x000001 → 0x999999, `overflow`=1;
  - `ppu`=0x000000, `pulse_count`=5 → 0x999999, `overflow`=1.
- `ce` toggled every other cycle with `pulse_count`=123456, `ppu`=0x000001 → 0x123456 after 134 clocks. An `update` with different inputs issued mid-conversion is ignored, and the result is unchanged.
- Reset mid-conversion:
  - complete one conversion so that `units_bcd`=0x000003;
  - start a new one, then assert `rst` on edge 20 → after that edge `ready`=1, `units_bcd`=0, `overflow`=0;
  - a fresh start then completes normally in 67 cycles.
